regfile_write_arbiter: RTL and testbench

//  Shares the RegisterFile's single write port between two writeback requesters:
//  ALU result (A) and memory load (B). Arbitration is round-robin.

---
 rtl/mips_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 33 +++
 rtl/regfile_write_arbiter.sv | 99 +++++++++
 tb/tb_regfile_write_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, register-0 index and requester IDs for the writeback path
package mips_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    localparam logic [2:0] ZERO_REG = 3'd0;

    typedef logic req_id_t;
    localparam req_id_t REQ_ALU = 1'b0;
    localparam req_id_t REQ_MEM = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with last-grant flop (ALU vs memory load)
module rr_arbiter2
    import mips_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic a_valid,
    input  logic b_valid,
    output logic grant_a,
    output logic grant_b
);

    req_id_t last_grant;
    logic    enable;

    assign enable  = rst_n && !stall;

    // Under contention the requester that did not win last time goes first.
    assign grant_a = enable && a_valid && (!b_valid || (last_grant == REQ_MEM));
    assign grant_b = enable && b_valid && (!a_valid || (last_grant == REQ_ALU));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= REQ_MEM;
        end else if (grant_a) begin
            last_grant <= REQ_ALU;
        end else if (grant_b) begin
            last_grant <= REQ_MEM;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the RegisterFile write port between ALU and load writeback
// Optional read-port forwarding of the in-flight write is enabled with RF_BYPASS_EN.
module regfile_write_arbiter #(
    parameter int DATA_W       = mips_pkg::DATA_W,
    parameter int ADDR_W       = mips_pkg::ADDR_W,
    parameter int ZERO_DISCARD = 1,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write_register,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] rd_reg_1,
    input  logic [ADDR_W-1:0] rd_reg_2,
    input  logic [DATA_W-1:0] rf_data_1,
    input  logic [DATA_W-1:0] rf_data_2,
    output logic [DATA_W-1:0] fwd_data_1,
    output logic [DATA_W-1:0] fwd_data_2,
    output logic [CNT_W-1:0]  conflict_cnt
);
    import mips_pkg::*;

    logic              grant_a;
    logic              grant_b;
    logic              transfer;
    logic              discard;
    logic              regwrite_q;
    logic [ADDR_W-1:0] win_reg;
    logic [DATA_W-1:0] win_data;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign transfer = grant_a || grant_b;
    assign win_reg  = grant_a ? a_reg  : b_reg;
    assign win_data = grant_a ? a_data : b_data;
    assign discard  = (ZERO_DISCARD != 0) && (win_reg == ADDR_W'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite_q     <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
            conflict_cnt   <= '0;
        end else begin
            if (transfer) begin
                regwrite_q     <= !discard;
                write_register <= win_reg;
                write_data     <= win_data;
            end else begin
                regwrite_q     <= 1'b0;
            end
            if (a_valid && b_valid && !stall && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

    // A beat already in the output register must not commit while reset is held.
    assign RegWrite = regwrite_q && rst_n;

`ifdef RF_BYPASS_EN
    logic hit_1;
    logic hit_2;
    logic zero_blocked;

    assign zero_blocked = (ZERO_DISCARD != 0) && (write_register == ADDR_W'(ZERO_REG));
    assign hit_1        = RegWrite && !zero_blocked && (write_register == rd_reg_1);
    assign hit_2        = RegWrite && !zero_blocked && (write_register == rd_reg_2);
    assign fwd_data_1   = hit_1 ? write_data : rf_data_1;
    assign fwd_data_2   = hit_2 ? write_data : rf_data_2;
`else
    logic unused_rd;

    assign unused_rd  = ^{rd_reg_1, rd_reg_2};
    assign fwd_data_1 = rf_data_1;
    assign fwd_data_2 = rf_data_2;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed vector bench with a behavioural RegisterFile model
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        a_valid, b_valid;
    logic [2:0]  a_reg, b_reg;
    logic [15:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        RegWrite;
    logic [2:0]  write_register;
    logic [15:0] write_data;
    logic [2:0]  rd_reg_1, rd_reg_2;
    logic [15:0] rf_data_1, rf_data_2;
    logic [15:0] fwd_data_1, fwd_data_2;
    logic [7:0]  conflict_cnt;

    logic        rf_clear;
    logic [15:0] rf [8];

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .a_valid        (a_valid),
        .a_reg          (a_reg),
        .a_data         (a_data),
        .a_ready        (a_ready),
        .b_valid        (b_valid),
        .b_reg          (b_reg),
        .b_data         (b_data),
        .b_ready        (b_ready),
        .RegWrite       (RegWrite),
        .write_register (write_register),
        .write_data     (write_data),
        .rd_reg_1       (rd_reg_1),
        .rd_reg_2       (rd_reg_2),
        .rf_data_1      (rf_data_1),
        .rf_data_2      (rf_data_2),
        .fwd_data_1     (fwd_data_1),
        .fwd_data_2     (fwd_data_2),
        .conflict_cnt   (conflict_cnt)
    );

    // RegisterFile: commits at the end of the cycle in which RegWrite is high.
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0100 + 16'(i);
        end else if (RegWrite) begin
            rf[write_register] <= write_data;
        end
    end
    assign rf_data_1 = rf[rd_reg_1];
    assign rf_data_2 = rf[rd_reg_2];

    typedef struct {
        logic        stall;
        logic        av;
        logic [2:0]  ar;
        logic [15:0] ad;
        logic        bv;
        logic [2:0]  br;
        logic [15:0] bd;
        logic        ea;
        logic        eb;
        logic        erw;
        logic [2:0]  ewr;
        logic [15:0] ewd;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t vt [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    initial begin
        // Starts just after a reset pulse, so last_grant=B and conflict_cnt=0.
        vt[0]  = '{1'b0, 1'b1, 3'd2, 16'd5,   1'b1, 3'd3, 16'd7,  1'b1, 1'b0, 1'b1, 3'd2, 16'd5,   8'd1};
        vt[1]  = '{1'b0, 1'b1, 3'd2, 16'd5,   1'b1, 3'd3, 16'd7,  1'b0, 1'b1, 1'b1, 3'd3, 16'd7,   8'd2};
        vt[2]  = '{1'b0, 1'b1, 3'd2, 16'd5,   1'b1, 3'd3, 16'd7,  1'b1, 1'b0, 1'b1, 3'd2, 16'd5,   8'd3};
        vt[3]  = '{1'b0, 1'b1, 3'd2, 16'd5,   1'b1, 3'd3, 16'd7,  1'b0, 1'b1, 1'b1, 3'd3, 16'd7,   8'd4};
        vt[4]  = '{1'b0, 1'b0, 3'd0, 16'd0,   1'b1, 3'd3, 16'd7,  1'b0, 1'b1, 1'b1, 3'd3, 16'd7,   8'd4};
        vt[5]  = '{1'b0, 1'b1, 3'd1, 16'd11,  1'b1, 3'd6, 16'd66, 1'b1, 1'b0, 1'b1, 3'd1, 16'd11,  8'd5};
        vt[6]  = '{1'b1, 1'b1, 3'd1, 16'd11,  1'b1, 3'd6, 16'd66, 1'b0, 1'b0, 1'b0, 3'd1, 16'd11,  8'd5};
        vt[7]  = '{1'b0, 1'b0, 3'd0, 16'd0,   1'b0, 3'd0, 16'd0,  1'b0, 1'b0, 1'b0, 3'd1, 16'd11,  8'd5};
        vt[8]  = '{1'b0, 1'b0, 3'd0, 16'd0,   1'b1, 3'd0, 16'd99, 1'b0, 1'b1, 1'b0, 3'd0, 16'd99,  8'd5};
        vt[9]  = '{1'b0, 1'b1, 3'd7, 16'hBEEF, 1'b0, 3'd0, 16'd0, 1'b1, 1'b0, 1'b1, 3'd7, 16'hBEEF, 8'd5};
        vt[10] = '{1'b0, 1'b1, 3'd5, 16'd1,   1'b1, 3'd5, 16'd2,  1'b0, 1'b1, 1'b1, 3'd5, 16'd2,   8'd6};
        vt[11] = '{1'b0, 1'b1, 3'd5, 16'd1,   1'b1, 3'd5, 16'd2,  1'b1, 1'b0, 1'b1, 3'd5, 16'd1,   8'd7};

        rf_clear = 1'b1;
        rst_n    = 1'b0;
        stall    = 1'b0;
        a_valid  = 1'b1; a_reg = 3'd2; a_data = 16'd5;
        b_valid  = 1'b1; b_reg = 3'd3; b_data = 16'd7;
        rd_reg_1 = 3'd4; rd_reg_2 = 3'd0;

        // Reset held two cycles with both requesters valid
        tick();
        rf_clear = 1'b0;
        tick();
        chk("reset_a_ready", 32'(a_ready), 32'd0);
        chk("reset_b_ready", 32'(b_ready), 32'd0);
        chk("reset_regwrite", 32'(RegWrite), 32'd0);
        chk("reset_cnt", 32'(conflict_cnt), 32'd0);
        chk("reset_wreg", 32'(write_register), 32'd0);
        chk("reset_wdata", 32'(write_data), 32'd0);
        a_valid = 1'b0; b_valid = 1'b0; rst_n = 1'b1;
        tick();

        // Single write of reg 4 = 20, with read port 1 watching reg 4
        a_valid = 1'b1; a_reg = 3'd4; a_data = 16'd20;
        #1;
        chk("single_a_ready", 32'(a_ready), 32'd1);
        chk("single_b_ready", 32'(b_ready), 32'd0);
        tick();
        a_valid = 1'b0;
        #1;
        chk("single_regwrite", 32'(RegWrite), 32'd1);
        chk("single_wreg", 32'(write_register), 32'd4);
        chk("single_wdata", 32'(write_data), 32'd20);
        chk("single_rf_old", 32'(rf_data_1), 32'h0104);
`ifdef RF_BYPASS_EN
        chk("fwd_n1", 32'(fwd_data_1), 32'd20);
`else
        chk("fwd_n1", 32'(fwd_data_1), 32'h0104);
`endif
        tick();
        chk("single_rf_new", 32'(rf_data_1), 32'd20);
        chk("fwd_n2", 32'(fwd_data_1), 32'd20);
        chk("single_regwrite_off", 32'(RegWrite), 32'd0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            stall = vt[i].stall;
            a_valid = vt[i].av; a_reg = vt[i].ar; a_data = vt[i].ad;
            b_valid = vt[i].bv; b_reg = vt[i].br; b_data = vt[i].bd;
            #1;
            chk($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(vt[i].ea));
            chk($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(vt[i].eb));
            tick();
            chk($sformatf("vec%0d_regwrite", i), 32'(RegWrite), 32'(vt[i].erw));
            chk($sformatf("vec%0d_wreg", i), 32'(write_register), 32'(vt[i].ewr));
            chk($sformatf("vec%0d_wdata", i), 32'(write_data), 32'(vt[i].ewd));
            chk($sformatf("vec%0d_cnt", i), 32'(conflict_cnt), 32'(vt[i].ecnt));
        end
        stall = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        rd_reg_1 = 3'd5; rd_reg_2 = 3'd0;
        tick();
        chk("same_reg_final", 32'(rf_data_1), 32'd1);
        chk("zero_reg_unchanged", 32'(rf_data_2), 32'h0100);
        chk("reg3_value", 32'(rf[3]), 32'd7);

        // Reset arrives the cycle after an accepted beat: the beat is dropped
        a_valid = 1'b1; a_reg = 3'd5; a_data = 16'd33;
        #1;
        chk("midop_a_ready", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("midop_regwrite_in_reset", 32'(RegWrite), 32'd0);
        tick();
        chk("midop_regwrite_after", 32'(RegWrite), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("midop_reg5_unchanged", 32'(rf_data_1), 32'd1);

        // Stall with both valid: no grants and no contention count
        stall = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk("stall_a_ready", 32'(a_ready), 32'd0);
        chk("stall_b_ready", 32'(b_ready), 32'd0);
        tick();
        chk("stall_cnt", 32'(conflict_cnt), 32'd0);
        chk("stall_regwrite", 32'(RegWrite), 32'd0);
        stall = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
